// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions for the ALU, the result stage and benches.
//   alu_op_e    : ALU opcode encoding (values above ALU_OP_LAST are illegal)
//   cond_e      : conditional branch condition encoding
//   FLAG_Z/N    : bit positions of zero/negative in the ALU flag vector
//   cond_met()  : evaluates a branch condition against Z/N
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_SUB = 4'd0,
        ALU_ADD = 4'd1,
        ALU_MUL = 4'd2,
        ALU_MOV = 4'd3,
        ALU_CMP = 4'd4,
        ALU_DIV = 4'd5,
        ALU_XOR = 4'd6,
        ALU_AND = 4'd7,
        ALU_NOT = 4'd8,
        ALU_SHL = 4'd9,
        ALU_SHR = 4'd10
    } alu_op_e;

    localparam logic [3:0] ALU_OP_LAST = 4'd10;

    typedef enum logic [1:0] {
        COND_AL = 2'd0,
        COND_EQ = 2'd1,
        COND_NE = 2'd2,
        COND_LT = 2'd3
    } cond_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;

    function automatic logic cond_met(input cond_e c, input logic z, input logic n);
        logic met;
        case (c)
            COND_AL: met = 1'b1;
            COND_EQ: met = z;
            COND_NE: met = ~z;
            COND_LT: met = n;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/alu_result_stage_skid.sv
// pipe_skid_reg: generic 2-entry valid/ready pipeline register.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drops both entries, blocks acceptance this cycle
//   in_valid/in_ready : upstream handshake; in_ready = !skid_valid && !rst
//   in_data           : payload presented upstream
//   in_accept         : high when the payload is taken at this edge
//   out_valid/out_ready/out_data : downstream handshake and payload
// The output register is the visible entry; the skid register catches an
// accepted payload while the output is stalled, which keeps in_ready a
// function of registered state only.
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         in_accept,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;

    assign in_ready  = !skid_valid_q && !rst;
    assign in_accept = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // A full skid implies in_ready was low, so no accept can
            // coincide with draining the skid into the output register.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_accept;
                if (in_accept) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute->writeback stage behind the ALU.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : upstream handshake
//   alu_result, alu_flags     : ALU result and {N,Z} flags
//   alu_select                : ALU opcode (>= 11 is illegal)
//   rd_addr, reg_write        : destination register and write request
//   set_flags                 : instruction updates the Z/N register
//   is_branch, cond           : conditional branch and its condition
//   flush                     : discard all in-flight entries
//   out_valid/out_ready       : writeback handshake
//   out_result, out_rd_addr, out_reg_write, out_branch_taken, out_illegal
//                             : registered entry fields
//   flag_z, flag_n            : architectural flag register
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          alu_result,
    input  logic [1:0]            alu_flags,
    input  logic [3:0]            alu_select,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_write,
    input  logic                  set_flags,
    input  logic                  is_branch,
    input  logic [1:0]            cond,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_result,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write,
    output logic                  out_branch_taken,
    output logic                  out_illegal,
    output logic                  flag_z,
    output logic                  flag_n
);

    localparam int PW = N + REG_ADDR_W + 3;

    logic          accept;
    logic          illegal;
    logic          is_cmp;
    logic          wr_eff;
    logic          taken;
    logic          upd_flags;
    logic [PW-1:0] pl_in, pl_out;
    logic          flag_z_q, flag_z_d;
    logic          flag_n_q, flag_n_d;

    assign illegal   = alu_select > ALU_OP_LAST;
    assign is_cmp    = alu_select == 4'(ALU_CMP);
    assign wr_eff    = reg_write && !is_branch && !is_cmp && !illegal;
    // Branch sees the flags committed before this edge; an instruction
    // setting flags in the same cycle only affects later branches.
    assign taken     = is_branch && cond_met(cond_e'(cond), flag_z_q, flag_n_q);
    assign upd_flags = accept && (set_flags || is_cmp) && !is_branch && !illegal;

    assign pl_in = {alu_result, rd_addr, wr_eff, taken, illegal};

    pipe_skid_reg #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pl_in),
        .in_accept (accept),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pl_out)
    );

    assign {out_result, out_rd_addr, out_reg_write, out_branch_taken, out_illegal} = pl_out;

    always_comb begin
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        if (upd_flags) begin
            flag_z_d = alu_flags[FLAG_Z];
            flag_n_d = alu_flags[FLAG_N];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;

endmodule
